// File: rtl/program_counter.sv
// Instruction-address register: each rising edge either loads a jump/branch
// target or steps to the next sequential address, wrapping modulo 2**ADDR_W.
module program_counter #(
  parameter int ADDR_W     = 6,
  parameter int RESET_ADDR = 0,
  parameter int STEP       = 1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] AddrIn,
  output logic [ADDR_W-1:0] AddrOut
);

  localparam logic [ADDR_W-1:0] ResetValue = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] StepValue  = ADDR_W'(STEP);

  logic [ADDR_W-1:0] nextAddr;

  // AddrIn is only selected under WriteEnable, so an unknown target cannot
  // leak into the sequential path.
  always_comb begin
    nextAddr = AddrOut + StepValue;
    if (WriteEnable) begin
      nextAddr = AddrIn;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      AddrOut <= ResetValue;
    end else begin
      AddrOut <= nextAddr;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: the driver pushes the expected address for
// each edge into exp_q, and a monitor pops and compares 2 ns after every edge.
module tb_program_counter;

  localparam int W = 6;

  logic         clk;
  logic         nReset;
  logic         WriteEnable;
  logic [W-1:0] AddrIn;
  logic [W-1:0] AddrOut;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run;
  int           tests_failed;

  program_counter #(.ADDR_W(W), .RESET_ADDR(0), .STEP(1)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .WriteEnable(WriteEnable),
    .AddrIn     (AddrIn),
    .AddrOut    (AddrOut)
  );

  // clock: first rising edge at 5 ns, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: AddrOut=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // drive inputs for the next rising edge, record the expected result, then
  // advance to the following falling edge
  task automatic tick(input logic we, input logic [W-1:0] addr,
                      input logic [W-1:0] exp, input string name);
    WriteEnable = we;
    AddrIn      = addr;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    string        n;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, AddrOut, e);
      end
    end
  end

  // watchdog
  initial begin
    #20000;
    tests_failed++;
    $display("FAIL watchdog: stimulus did not complete by %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    nReset       = 1'b0;
    WriteEnable  = 1'b0;
    AddrIn       = 6'd22;

    // 1: reset value with no clock edge yet, then through the 5 ns edge
    #1;
    check("reset_immediate", AddrOut, 6'd0);
    exp_q.push_back(6'd0);
    name_q.push_back("reset_edge5");
    #5;
    nReset = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0, 6'd22, W'(k), "count_after_reset");
    end

    // 2: load 0, then increment ignoring AddrIn=55
    tick(1'b1, 6'd0, 6'd0, "load_zero");
    tick(1'b0, 6'd55, 6'd1, "ignore_addrin_1");
    tick(1'b0, 6'd55, 6'd2, "ignore_addrin_2");
    tick(1'b0, 6'd55, 6'd3, "ignore_addrin_3");

    // 3: jump to 26, continue counting
    tick(1'b1, 6'd26, 6'd26, "load_26");
    tick(1'b0, 6'd26, 6'd27, "inc_27");
    tick(1'b0, 6'd0,  6'd28, "inc_28");
    tick(1'b0, 6'd9,  6'd29, "inc_29");

    // 4: wrap-around from 63
    tick(1'b1, 6'd62, 6'd62, "load_62");
    tick(1'b0, 6'd0,  6'd63, "inc_63");
    tick(1'b0, 6'd0,  6'd0,  "wrap_0");
    tick(1'b0, 6'd0,  6'd1,  "wrap_1");

    // load of the current value holds it
    tick(1'b1, 6'd1, 6'd1, "load_same");
    tick(1'b1, 6'd63, 6'd63, "load_max");
    tick(1'b0, 6'd5,  6'd0,  "max_plus_one");

    // unknown AddrIn while incrementing must not propagate
    tick(1'b0, 'x, 6'd1, "x_addrin_ignored");

    // 5: asynchronous reset mid-run
    tick(1'b1, 6'd40, 6'd40, "load_40");
    nReset = 1'b0;
    #1;
    check("async_reset_between_edges", AddrOut, 6'd0);

    // 6: reset dominates WriteEnable over several edges
    tick(1'b1, 6'd17, 6'd0, "reset_over_load_1");
    tick(1'b1, 6'd17, 6'd0, "reset_over_load_2");
    tick(1'b1, 6'd17, 6'd0, "reset_over_load_3");

    nReset = 1'b1;
    tick(1'b0, 6'd17, 6'd1, "restart_1");
    tick(1'b0, 6'd17, 6'd2, "restart_2");
    tick(1'b0, 6'd17, 6'd3, "restart_3");

    @(posedge clk);
    #3;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
